// File: rtl/dvb_s2_dec_axis_packer.sv
// dvb_s2_dec_axis_packer
// Packs the decoder's bit-serial hard-decision stream into an 8-bit AXI4-Stream
// master with per-frame tid/tdest/tuser sideband, and reports per-frame status.
// Optional build macro: DVB_S2_DEC_PACKER_LSB_FIRST_EN (first bit of a byte -> tdata[0]).
module dvb_s2_dec_axis_packer #(
    parameter int unsigned pMAX_BITS = 14232
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic        ival,
    input  logic        isop,
    input  logic        ieop,
    input  logic        idat,
    input  logic [20:0] itag,
    input  logic        idecfail,
    output logic        ordy,
    input  logic        m_axis_tready,
    output logic        m_axis_tvalid,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tlast,
    output logic [7:0]  m_axis_tid,
    output logic [3:0]  m_axis_tdest,
    output logic [8:0]  m_axis_tuser,
    output logic        oframe_done,
    output logic [15:0] oframe_bitnum,
    output logic        oframe_error
);

    localparam logic [15:0] MAX_BITS = 16'(pMAX_BITS);

    typedef enum logic {
        IDLE,
        FRAME
    } state_t;

    typedef struct packed {
        logic [7:0]  data;
        logic        last;
        logic [20:0] tag;
    } ent_t;

    state_t      state_q, state_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  nb_q, nb_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic [20:0] tag_q, tag_d;
    logic [1:0]  fcnt_q, fcnt_d;
    ent_t        mem_q [0:2];
    ent_t        mem_d [0:2];
    logic        rdy_q, rdy_d;
    logic        done_q, done_d;
    logic [15:0] bitnum_q, bitnum_d;
    logic        err_q, err_d;

    logic        acc, pop, start;
    logic        push_a, push_b;
    ent_t        ent_a, ent_b;
    logic [7:0]  byte_v;
    logic [1:0]  wp;

    // Bit position within the byte for the k-th bit of that byte.
    function automatic logic [2:0] bitpos(input logic [2:0] k);
`ifdef DVB_S2_DEC_PACKER_LSB_FIRST_EN
        return k;
`else
        return 3'd7 - k;
`endif
    endfunction

    assign acc = ival & rdy_q;
    assign pop = (fcnt_q != 2'd0) & m_axis_tready;

    // Framing FSM, bit packing, status and output FIFO next state.
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        nb_d     = nb_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        tag_d    = tag_q;
        done_d   = 1'b0;
        bitnum_d = bitnum_q;
        err_d    = err_q;
        start    = 1'b0;
        push_a   = 1'b0;
        push_b   = 1'b0;
        ent_a    = '0;
        ent_b    = '0;
        byte_v   = '0;

        case (state_q)
            IDLE: begin
                if (acc && isop) start = 1'b1;
            end
            FRAME: begin
                if (acc && isop) begin
                    // Abort: pending bits (zero-padded) or an empty byte close the old frame,
                    // unless the length cap has already emitted its tlast.
                    if (cnt_q != MAX_BITS) begin
                        push_a = 1'b1;
                        ent_a  = '{data: sh_q, last: 1'b1, tag: tag_q};
                    end
                    done_d   = 1'b1;
                    bitnum_d = cnt_q;
                    err_d    = 1'b1;
                    start    = 1'b1;
                end else if (acc) begin
                    if (cnt_q != MAX_BITS) begin
                        byte_v = sh_q;
                        byte_v[bitpos(nb_q)] = idat;
                        cnt_d  = cnt_q + 16'd1;
                        if (nb_q == 3'd7 || ieop || cnt_d == MAX_BITS) begin
                            push_a = 1'b1;
                            ent_a  = '{data: byte_v, last: (ieop || cnt_d == MAX_BITS), tag: tag_q};
                            sh_d   = '0;
                            nb_d   = '0;
                        end else begin
                            sh_d = byte_v;
                            nb_d = nb_q + 3'd1;
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (ieop) begin
                        done_d   = 1'b1;
                        bitnum_d = cnt_d;
                        err_d    = idecfail | ovf_d;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            tag_d   = itag;
            cnt_d   = 16'd1;
            ovf_d   = 1'b0;
            state_d = FRAME;
            byte_v  = '0;
            byte_v[bitpos(3'd0)] = idat;
            if (ieop) begin
                push_b   = 1'b1;
                ent_b    = '{data: byte_v, last: 1'b1, tag: itag};
                sh_d     = '0;
                nb_d     = '0;
                done_d   = 1'b1;
                bitnum_d = 16'd1;
                err_d    = idecfail;
                state_d  = IDLE;
            end else begin
                sh_d = byte_v;
                nb_d = 3'd1;
            end
        end

        // Shift FIFO with registered head; a third slot absorbs the double push of an
        // abort immediately followed by a 1-bit frame, while ordy still reports two.
        mem_d = mem_q;
        if (pop) begin
            mem_d[0] = mem_q[1];
            mem_d[1] = mem_q[2];
        end
        wp = fcnt_q - {1'b0, pop};
        if (push_a) begin
            mem_d[wp] = ent_a;
            wp        = wp + 2'd1;
        end
        if (push_b) mem_d[wp] = ent_b;
        fcnt_d = fcnt_q - {1'b0, pop} + {1'b0, push_a} + {1'b0, push_b};
        rdy_d  = (fcnt_d < 2'd2);
    end

    // State, packing, FIFO and status registers.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q  <= IDLE;
            sh_q     <= '0;
            nb_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            tag_q    <= '0;
            fcnt_q   <= '0;
            for (int unsigned i = 0; i < 3; i++) mem_q[i] <= '0;
            rdy_q    <= 1'b0;
            done_q   <= 1'b0;
            bitnum_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            nb_q     <= nb_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            tag_q    <= tag_d;
            fcnt_q   <= fcnt_d;
            for (int unsigned i = 0; i < 3; i++) mem_q[i] <= mem_d[i];
            rdy_q    <= rdy_d;
            done_q   <= done_d;
            bitnum_q <= bitnum_d;
            err_q    <= err_d;
        end
    end

    assign ordy          = rdy_q;
    assign m_axis_tvalid = (fcnt_q != 2'd0);
    assign m_axis_tdata  = mem_q[0].data;
    assign m_axis_tlast  = mem_q[0].last;
    assign m_axis_tid    = mem_q[0].tag[20:13];
    assign m_axis_tdest  = mem_q[0].tag[12:9];
    assign m_axis_tuser  = mem_q[0].tag[8:0];
    assign oframe_done   = done_q;
    assign oframe_bitnum = bitnum_q;
    assign oframe_error  = err_q;

endmodule
